// File: rtl/control_sequencer_pkg.sv
// Shared types for the fetch/decode/control sequencer:
// opcodes, ALU op encodings, FSM states and the control bundle.
package control_sequencer_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LI   = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       mem_write;
    logic       mem_read;
    logic       reg_data_sel;
    logic       alu_sel;
    logic       mem_data_sel;
    logic       reg_write;
  } ctrl_t;

  function automatic ctrl_t alu_ctrl(input logic [1:0] op);
    ctrl_t c;
    c = '0;
    c.alu_op       = op;
    c.reg_data_sel = 1'b1;
    c.reg_write    = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/control_sequencer_ctrl_decode.sv
// Opcode to control-bundle decoder; purely combinational and
// unqualified, the sequencer gates it with the EXEC state.
module ctrl_decode
  import control_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    unique case (opcode)
      OP_NOP:  ctrl = '0;
      OP_ADD:  ctrl = alu_ctrl(ALU_ADD);
      OP_SUB:  ctrl = alu_ctrl(ALU_SUB);
      OP_AND:  ctrl = alu_ctrl(ALU_AND);
      OP_OR:   ctrl = alu_ctrl(ALU_OR);
      OP_LI: begin
        ctrl.reg_data_sel = 1'b0;
        ctrl.reg_write    = 1'b1;
      end
      OP_LD: begin
        ctrl.mem_read     = 1'b1;
        ctrl.mem_data_sel = 1'b1;
        ctrl.reg_data_sel = 1'b1;
        ctrl.reg_write    = 1'b1;
      end
      OP_ST:   ctrl.mem_write = 1'b1;
      OP_BEQZ: begin
        ctrl.alu_op  = ALU_ADD;
        ctrl.alu_sel = 1'b1;
      end
      OP_JMP:  ctrl = '0;
      OP_HALT: ctrl = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/control unit: fetches over a req/valid handshake,
// holds IR and issues the Datapath control bundle for one EXEC cycle.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_data,
  output logic [15:0]     in_instruction,
  output logic [1:0]      c_ALUOp,
  output logic            c_MemWrite,
  output logic            c_MemRead,
  output logic            c_RegDataSel,
  output logic            c_AluSel,
  output logic            c_MemDataSel,
  output logic            c_RegWrite,
  output logic            ready,
  input  logic            c_zero,
  output logic            halted,
  output logic            illegal_op,
  output logic [15:0]     retired_cnt
);

  state_t          state;
  state_t          state_nx;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_nx;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] imm_ext;
  logic [15:0]     ir;
  logic [15:0]     retired;
  logic [3:0]      opcode;
  ctrl_t           dec_ctrl;
  ctrl_t           ctrl;
  logic            dec_ill;
  logic            exec;
  logic            take;

  assign opcode = ir[15:12];
  assign exec   = (state == EXEC);

  ctrl_decode u_dec (
    .opcode  (opcode),
    .ctrl    (dec_ctrl),
    .illegal (dec_ill)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (run) state_nx = FETCH;
      FETCH:   if (imem_valid) state_nx = EXEC;
      EXEC:    state_nx = (opcode == OP_HALT) ? HALT : FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  // Branch offset is relative to PC+1, modulo the PC width.
  always_comb begin
    imm_ext = PC_W'($signed(ir[7:0]));
    pc_inc  = pc + PC_W'(1);
    take    = (opcode == OP_JMP) ||
              ((opcode == OP_BEQZ) && c_zero);
    pc_nx   = take ? (pc_inc + imm_ext) : pc_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= PC_W'(RESET_PC);
      ir      <= '0;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH && imem_valid)
        ir <= imem_data;
      if (exec) begin
        pc      <= pc_nx;
        retired <= retired + 16'd1;
      end
    end
  end

  assign ctrl           = exec ? dec_ctrl : '0;
  assign c_ALUOp        = ctrl.alu_op;
  assign c_MemWrite     = ctrl.mem_write;
  assign c_MemRead      = ctrl.mem_read;
  assign c_RegDataSel   = ctrl.reg_data_sel;
  assign c_AluSel       = ctrl.alu_sel;
  assign c_MemDataSel   = ctrl.mem_data_sel;
  assign c_RegWrite     = ctrl.reg_write;
  assign illegal_op     = exec & dec_ill;
  assign ready          = exec;
  assign imem_req       = (state == FETCH);
  assign imem_addr      = pc;
  assign halted         = (state == HALT);
  assign in_instruction = ir;
  assign retired_cnt    = retired;

endmodule
